// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM.
package ctrl_pkg;

   localparam int unsigned OPC_W = 7;
   localparam int unsigned AOP_W = 2;

   localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

   localparam logic [AOP_W-1:0] ALUOP_ADD  = 2'b00;
   localparam logic [AOP_W-1:0] ALUOP_SUB  = 2'b01;
   localparam logic [AOP_W-1:0] ALUOP_RFUN = 2'b10;
   localparam logic [AOP_W-1:0] ALUOP_IFUN = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_IF   = 3'd1,
      ST_ID   = 3'd2,
      ST_EX   = 3'd3,
      ST_MEM  = 3'd4,
      ST_WB   = 3'd5,
      ST_TRAP = 3'd6
   } state_e;

   typedef struct packed {
      logic is_r;
      logic is_i;
      logic is_ld;
      logic is_st;
      logic is_br;
      logic legal;
   } op_class_t;

endpackage

// File: rtl/ctrl_op_class.sv
// Opcode classifier: one-hot instruction class plus a legality flag.
module ctrl_op_class
   import ctrl_pkg::*;
#(
   parameter int unsigned OP_W = 7
) (
   input  logic [OP_W-1:0] op_i,
   output op_class_t       cls_o
);

   // Decode each supported opcode; anything else is illegal
   always_comb begin
      cls_o       = '0;
      cls_o.is_r  = (op_i == OP_W'(OP_R));
      cls_o.is_i  = (op_i == OP_W'(OP_I));
      cls_o.is_ld = (op_i == OP_W'(OP_LOAD));
      cls_o.is_st = (op_i == OP_W'(OP_STORE));
      cls_o.is_br = (op_i == OP_W'(OP_BRANCH));
      cls_o.legal = cls_o.is_r | cls_o.is_i | cls_o.is_ld | cls_o.is_st | cls_o.is_br;
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences IF/ID/EX/MEM/WB, traps illegal
// opcodes and counts retired instructions.
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int unsigned OP_W          = 7,
   parameter int unsigned ALUOP_W       = 2,
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned MEM_HANDSHAKE = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [OP_W-1:0]    op_i,
   input  logic               imem_ready_i,
   input  logic               dmem_ready_i,
   output logic               imem_req_o,
   output logic               ir_write_o,
   output logic               pc_write_o,
   output logic               branch_o,
   output logic               ALUSrc_o,
   output logic [ALUOP_W-1:0] ALUOp_o,
   output logic               dmem_req_o,
   output logic               dmem_we_o,
   output logic               MemtoReg_o,
   output logic               RegWrite_o,
   output logic               illegal_o,
   output logic [CNT_W-1:0]   retired_o
);

   state_e            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic [OP_W-1:0]   cls_op_c;
   op_class_t         cls_c;
   logic              imem_go_c;
   logic              dmem_go_c;
   logic              retire_c;

   // Classify the live opcode in ID, the latched one everywhere else
   assign cls_op_c = (state_q == ST_ID) ? op_i : op_q;

   ctrl_op_class #(.OP_W(OP_W)) u_op_class (
      .op_i  (cls_op_c),
      .cls_o (cls_c)
   );

   // Without the handshake the memories are treated as single-cycle
   assign imem_go_c = (MEM_HANDSHAKE == 0) || imem_ready_i;
   assign dmem_go_c = (MEM_HANDSHAKE == 0) || dmem_ready_i;
   assign retired_o = retired_q;

   // State, opcode and retire counter registers; reset wins over everything
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         retired_q <= retired_d;
      end
   end

   // Next-state and Moore outputs; IF write strobes are the only ready-gated outputs
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      retired_d  = retired_q;
      retire_c   = 1'b0;
      imem_req_o = 1'b0;
      ir_write_o = 1'b0;
      pc_write_o = 1'b0;
      branch_o   = 1'b0;
      ALUSrc_o   = 1'b0;
      ALUOp_o    = ALUOP_W'(ALUOP_ADD);
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      MemtoReg_o = 1'b0;
      RegWrite_o = 1'b0;
      illegal_o  = 1'b0;

      case (state_q)
         ST_IDLE: state_d = ST_IF;
         ST_IF: begin
            imem_req_o = 1'b1;
            if (imem_go_c) begin
               ir_write_o = 1'b1;
               pc_write_o = 1'b1;
               state_d    = ST_ID;
            end
         end
         ST_ID: begin
            op_d    = op_i;
            state_d = cls_c.legal ? ST_EX : ST_TRAP;
         end
         ST_EX: begin
            if (cls_c.is_r) begin
               ALUOp_o = ALUOP_W'(ALUOP_RFUN);
               state_d = ST_WB;
            end else if (cls_c.is_i) begin
               ALUOp_o  = ALUOP_W'(ALUOP_IFUN);
               ALUSrc_o = 1'b1;
               state_d  = ST_WB;
            end else if (cls_c.is_ld || cls_c.is_st) begin
               ALUOp_o  = ALUOP_W'(ALUOP_ADD);
               ALUSrc_o = 1'b1;
               state_d  = ST_MEM;
            end else if (cls_c.is_br) begin
               ALUOp_o  = ALUOP_W'(ALUOP_SUB);
               branch_o = 1'b1;
               retire_c = 1'b1;
               state_d  = ST_IF;
            end else begin
               state_d = ST_TRAP;
            end
         end
         ST_MEM: begin
            dmem_req_o = 1'b1;
            dmem_we_o  = cls_c.is_st;
            if (dmem_go_c) begin
               if (cls_c.is_ld) begin
                  state_d = ST_WB;
               end else begin
                  retire_c = 1'b1;
                  state_d  = ST_IF;
               end
            end
         end
         ST_WB: begin
            RegWrite_o = 1'b1;
            MemtoReg_o = cls_c.is_ld;
            retire_c   = 1'b1;
            state_d    = ST_IF;
         end
         ST_TRAP: illegal_o = 1'b1;
         default: state_d = ST_IDLE;
      endcase

      if (retire_c) begin
         retired_d = retired_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (handshaking 32-bit counter,
// and no-handshake 4-bit counter) checked every cycle against a step-plan model.
module tb_multicycle_control;

   localparam logic [6:0] T_R  = 7'b0110011;
   localparam logic [6:0] T_I  = 7'b0010011;
   localparam logic [6:0] T_LD = 7'b0000011;
   localparam logic [6:0] T_ST = 7'b0100011;
   localparam logic [6:0] T_BR = 7'b1100011;

   localparam int P_IDLE = 0;
   localparam int P_IF   = 1;
   localparam int P_ID   = 2;
   localparam int P_EX   = 3;
   localparam int P_MEM  = 4;
   localparam int P_WB   = 5;
   localparam int P_TRAP = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic       iready;
   logic       dready;

   logic        d0_imem_req, d0_ir_write, d0_pc_write, d0_branch, d0_alusrc;
   logic [1:0]  d0_aluop;
   logic        d0_dmem_req, d0_dmem_we, d0_memtoreg, d0_regwrite, d0_illegal;
   logic [31:0] d0_ret;
   logic        d1_imem_req, d1_ir_write, d1_pc_write, d1_branch, d1_alusrc;
   logic [1:0]  d1_aluop;
   logic        d1_dmem_req, d1_dmem_we, d1_memtoreg, d1_regwrite, d1_illegal;
   logic [3:0]  d1_ret;

   int total = 0;
   int bad   = 0;

   int          m_ph  [2];
   logic [6:0]  m_op  [2];
   int          m_idx [2];
   int unsigned m_ret [2];

   always #5 clk = ~clk;

   multicycle_control #(.OP_W(7), .ALUOP_W(2), .CNT_W(32), .MEM_HANDSHAKE(1)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .op_i(op), .imem_ready_i(iready), .dmem_ready_i(dready),
      .imem_req_o(d0_imem_req), .ir_write_o(d0_ir_write), .pc_write_o(d0_pc_write),
      .branch_o(d0_branch), .ALUSrc_o(d0_alusrc), .ALUOp_o(d0_aluop),
      .dmem_req_o(d0_dmem_req), .dmem_we_o(d0_dmem_we), .MemtoReg_o(d0_memtoreg),
      .RegWrite_o(d0_regwrite), .illegal_o(d0_illegal), .retired_o(d0_ret)
   );

   multicycle_control #(.OP_W(7), .ALUOP_W(2), .CNT_W(4), .MEM_HANDSHAKE(0)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .op_i(op), .imem_ready_i(iready), .dmem_ready_i(dready),
      .imem_req_o(d1_imem_req), .ir_write_o(d1_ir_write), .pc_write_o(d1_pc_write),
      .branch_o(d1_branch), .ALUSrc_o(d1_alusrc), .ALUOp_o(d1_aluop),
      .dmem_req_o(d1_dmem_req), .dmem_we_o(d1_dmem_we), .MemtoReg_o(d1_memtoreg),
      .RegWrite_o(d1_regwrite), .illegal_o(d1_illegal), .retired_o(d1_ret)
   );

   function automatic bit is_legal(logic [6:0] o);
      return (o == T_R) || (o == T_I) || (o == T_LD) || (o == T_ST) || (o == T_BR);
   endfunction

   // Phases an instruction walks through after decode
   function automatic int plan_len(logic [6:0] o);
      if (o == T_LD) return 3;
      if (o == T_BR) return 1;
      return 2;
   endfunction

   function automatic int plan_step(logic [6:0] o, int i);
      if (i == 0) return P_EX;
      if (o == T_LD) return (i == 1) ? P_MEM : P_WB;
      if (o == T_ST) return P_MEM;
      return P_WB;
   endfunction

   // Expected {imem_req, ir_write, pc_write, branch, alusrc, aluop, dmem_req, dmem_we, memtoreg, regwrite, illegal}
   function automatic logic [11:0] exp_out(int ph, logic [6:0] o, logic ir, bit hs);
      logic imr, irw, pcw, br, src, dr, dw, m2r, rw, ill;
      logic [1:0] aop;
      {imr, irw, pcw, br, src, dr, dw, m2r, rw, ill} = '0;
      aop = 2'b00;
      case (ph)
         P_IF: begin
            imr = 1'b1;
            if (!hs || ir) begin irw = 1'b1; pcw = 1'b1; end
         end
         P_EX: begin
            if (o == T_R) aop = 2'b10;
            else if (o == T_I) begin aop = 2'b11; src = 1'b1; end
            else if (o == T_LD || o == T_ST) begin aop = 2'b00; src = 1'b1; end
            else if (o == T_BR) begin aop = 2'b01; br = 1'b1; end
         end
         P_MEM: begin dr = 1'b1; dw = (o == T_ST); end
         P_WB: begin rw = 1'b1; m2r = (o == T_LD); end
         P_TRAP: ill = 1'b1;
         default: ;
      endcase
      return {imr, irw, pcw, br, src, aop, dr, dw, m2r, rw, ill};
   endfunction

   task automatic model_step(int k);
      bit hs;
      hs = (k == 0);
      if (rst) begin
         m_ph[k] = P_IDLE; m_op[k] = '0; m_idx[k] = 0; m_ret[k] = 0;
         return;
      end
      case (m_ph[k])
         P_IDLE: m_ph[k] = P_IF;
         P_IF:   if (!hs || iready) m_ph[k] = P_ID;
         P_ID: begin
            m_op[k] = op;
            if (is_legal(op)) begin
               m_idx[k] = 0;
               m_ph[k]  = plan_step(op, 0);
            end else begin
               m_ph[k] = P_TRAP;
            end
         end
         P_EX, P_MEM, P_WB: begin
            if (!(m_ph[k] == P_MEM && hs && !dready)) begin
               m_idx[k]++;
               if (m_idx[k] == plan_len(m_op[k])) begin
                  m_ph[k] = P_IF;
                  m_ret[k]++;
               end else begin
                  m_ph[k] = plan_step(m_op[k], m_idx[k]);
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h t=%0t", name, got, want, $time);
      end
   endtask

   // Advance one clock (model tracks DUT), then compare all outputs against the model
   task automatic cycle();
      logic [11:0] act, exp;
      logic [31:0] ra, re;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            act = {d0_imem_req, d0_ir_write, d0_pc_write, d0_branch, d0_alusrc, d0_aluop,
                   d0_dmem_req, d0_dmem_we, d0_memtoreg, d0_regwrite, d0_illegal};
            ra  = d0_ret;
            re  = m_ret[0];
         end else begin
            act = {d1_imem_req, d1_ir_write, d1_pc_write, d1_branch, d1_alusrc, d1_aluop,
                   d1_dmem_req, d1_dmem_we, d1_memtoreg, d1_regwrite, d1_illegal};
            ra  = 32'(d1_ret);
            re  = m_ret[1] & 32'hF;
         end
         exp = exp_out(m_ph[k], m_op[k], iready, k == 0);
         total++;
         if (act !== exp) begin
            bad++;
            $display("FAIL outputs dut%0d: got=%b want=%b phase=%0d t=%0t", k, act, exp, m_ph[k], $time);
         end
         total++;
         if (ra !== re) begin
            bad++;
            $display("FAIL retired dut%0d: got=%0d want=%0d t=%0t", k, ra, re, $time);
         end
      end
   endtask

   initial begin
      logic [6:0] legal_ops [5];
      logic [6:0] rnd;
      int trap_cnt;
      legal_ops = '{T_R, T_I, T_LD, T_ST, T_BR};
      trap_cnt  = 0;

      rst = 1'b1; op = T_R; iready = 1'b1; dready = 1'b1;
      repeat (3) cycle();
      chk("rst_imem_req", 32'(d0_imem_req), 32'd0);
      chk("rst_retired", d0_ret, 32'd0);
      chk("rst_illegal", 32'(d0_illegal), 32'd0);
      rst = 1'b0;

      // R-type with ready memories
      cycle(); chk("r_if_req", 32'(d0_imem_req), 32'd1); chk("r_if_irw", 32'(d0_ir_write), 32'd1);
      cycle();
      cycle(); chk("r_ex_aluop", 32'(d0_aluop), 32'd2); chk("r_ex_alusrc", 32'(d0_alusrc), 32'd0);
      cycle(); chk("r_wb_regwrite", 32'(d0_regwrite), 32'd1); chk("r_wb_ret", d0_ret, 32'd0);
      cycle(); chk("r_retired", d0_ret, 32'd1); chk("nohs_r_4cyc", 32'(d1_ret), 32'd1);

      // LOAD with data memory stalling three cycles
      op = T_LD; dready = 1'b0;
      cycle();
      cycle(); chk("ld_ex_aluop", 32'(d0_aluop), 32'd0); chk("ld_ex_alusrc", 32'(d0_alusrc), 32'd1);
      cycle(); chk("ld_mem_req", 32'(d0_dmem_req), 32'd1);
      repeat (3) begin
         cycle(); chk("ld_mem_hold", 32'(d0_dmem_req), 32'd1); chk("ld_mem_we", 32'(d0_dmem_we), 32'd0);
      end
      dready = 1'b1;
      cycle(); chk("ld_wb_m2r", 32'(d0_memtoreg), 32'd1); chk("ld_wb_ret", d0_ret, 32'd1);
      cycle(); chk("ld_retired", d0_ret, 32'd2);

      // STORE skips WB and never writes the register file
      op = T_ST;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("st_no_regwrite", 32'(d0_regwrite), 32'd0);
         if (i == 2) chk("st_mem_we", 32'(d0_dmem_we), 32'd1);
      end
      chk("st_retired", d0_ret, 32'd3);

      // Illegal opcode traps until reset
      op = 7'b1111111;
      cycle();
      cycle(); chk("trap_illegal", 32'(d0_illegal), 32'd1);
      repeat (20) begin
         cycle(); chk("trap_hold", 32'(d0_illegal), 32'd1); chk("trap_no_fetch", 32'(d0_imem_req), 32'd0);
      end
      rst = 1'b1;
      cycle(); chk("trap_cleared", 32'(d0_illegal), 32'd0); chk("trap_ret_clr", d0_ret, 32'd0);
      rst = 1'b0;
      cycle(); chk("trap_refetch", 32'(d0_imem_req), 32'd1);

      // Reset while stalled in MEM
      op = T_R;
      repeat (4) cycle();
      chk("mr_ret_before", d0_ret, 32'd1);
      op = T_LD; dready = 1'b0;
      repeat (4) cycle();
      chk("mr_mem_waiting", 32'(d0_dmem_req), 32'd1);
      rst = 1'b1;
      cycle(); chk("mr_req_dropped", 32'(d0_dmem_req), 32'd0); chk("mr_ret_clr", d0_ret, 32'd0);
      rst = 1'b0; dready = 1'b1;

      // 17 branches: 4-bit counter wraps to 1
      rst = 1'b1; cycle(); rst = 1'b0;
      op = T_BR; iready = 1'b1;
      for (int c = 1; c <= 52; c++) begin
         cycle();
         if (c % 3 == 0) begin
            chk("br_branch", 32'(d1_branch), 32'd1);
            chk("br_aluop", 32'(d1_aluop), 32'd1);
         end
      end
      chk("br_wrap4", 32'(d1_ret), 32'd1);
      chk("br_count32", d0_ret, 32'd17);

      // Randomized traffic with sporadic resets and traps
      for (int c = 0; c < 4000; c++) begin
         rst    = ($urandom_range(0, 299) == 0) || (trap_cnt > 8);
         iready = ($urandom_range(0, 2) != 0);
         dready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 24) == 0) begin
            rnd = 7'($urandom);
            op  = is_legal(rnd) ? 7'b1111111 : rnd;
         end else begin
            op = legal_ops[$urandom_range(0, 4)];
         end
         cycle();
         trap_cnt = (m_ph[0] == P_TRAP || m_ph[1] == P_TRAP) ? trap_cnt + 1 : 0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
